// File: rtl/tag_commit_sequencer.sv
// Read-side controller for the in-order tag FIFO: tracks occupancy and CDB completions,
// and offers each completed head tag on a valid/ready commit port, popping on handshake.
module tag_commit_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_WIDTH  = 4,
    localparam int unsigned CntWidth  = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned NumTags   = 2 ** TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alloc,
    input  logic [TAG_WIDTH-1:0] alloc_tag,
    input  logic [TAG_WIDTH-1:0] front_tag,
    output logic                 pop,
    input  logic                 cdb_valid,
    input  logic [TAG_WIDTH-1:0] cdb_tag,
    output logic                 commit_valid,
    output logic [TAG_WIDTH-1:0] commit_tag,
    input  logic                 commit_ready,
    output logic                 empty,
    output logic [CntWidth-1:0]  count,
    output logic                 overflow
);

    typedef enum logic [1:0] {StIdle, StWait, StCommit} state_e;

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  count_q, count_d;
    logic [NumTags-1:0]   done_q, done_d;
    logic [TAG_WIDTH-1:0] commit_tag_q, commit_tag_d;
    logic                 overflow_q, overflow_d;

    logic handshake;
    logic full;
    logic alloc_acc;
    logic head_done;

    always_comb begin
        handshake = (state_q == StCommit) & commit_ready;
        full      = (count_q == CntWidth'(FIFO_DEPTH));
        // A full FIFO still takes a push when the head pops in the same cycle.
        alloc_acc = alloc & (~full | handshake);
        head_done = done_q[front_tag] | (cdb_valid & (cdb_tag == front_tag));

        overflow_d = overflow_q | (alloc & full & ~handshake);
        count_d    = count_q + CntWidth'(alloc_acc) - CntWidth'(handshake);

        // Priority: commit clear < CDB set < alloc clear (stale completion removal).
        done_d = done_q;
        if (handshake) begin
            done_d[commit_tag_q] = 1'b0;
        end
        if (cdb_valid) begin
            done_d[cdb_tag] = 1'b1;
        end
        if (alloc_acc) begin
            done_d[alloc_tag] = 1'b0;
        end

        state_d      = state_q;
        commit_tag_d = commit_tag_q;
        unique case (state_q)
            StIdle: begin
                if (count_d != '0) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (head_done) begin
                    state_d      = StCommit;
                    commit_tag_d = front_tag;
                end
            end
            StCommit: begin
                if (handshake) begin
                    state_d = (count_d == '0) ? StIdle : StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            count_q      <= '0;
            done_q       <= '0;
            commit_tag_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            done_q       <= done_d;
            commit_tag_q <= commit_tag_d;
            overflow_q   <= overflow_d;
        end
    end

    assign commit_valid = (state_q == StCommit);
    assign commit_tag   = commit_tag_q;
    assign pop          = handshake;
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign overflow     = overflow_q;

endmodule
